// File: rtl/debug_loader.sv
// Serial debug loader: writes a program received byte-by-byte into program memory,
// runs the CPU until it halts, then reports the halt PC and cycle count over the link.
module debug_loader #(
  parameter int NBITS_O = 11,
  parameter int NBITS_D = 16,
  parameter int NBITS_B = 8
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NBITS_B-1:0] i_RxData,
  input  logic               i_RxDone,
  input  logic               i_TxDone,
  input  logic               i_Halt,
  input  logic [NBITS_O-1:0] i_PmAddr,
  output logic               o_PmWrEn,
  output logic [NBITS_O-1:0] o_PmWrAddr,
  output logic [NBITS_D-1:0] o_PmWrData,
  output logic               o_CpuRstN,
  output logic               o_CpuEn,
  output logic [NBITS_B-1:0] o_TxData,
  output logic               o_TxStart
);

  // IDLE: wait count byte | LD_HI/LD_LO: load words | RUN: cpu running | SEND/WAIT_TX: halt report
  typedef enum logic [2:0] {IDLE, LD_HI, LD_LO, RUN, SEND, WAIT_TX} state_t;

  state_t             state, state_nxt;
  logic [NBITS_B-1:0] n_q, n_nxt;
  logic [NBITS_B-1:0] idx_q, idx_nxt;
  logic [NBITS_B-1:0] hi_q, hi_nxt;
  logic [1:0]         k_q, k_nxt;
  logic [15:0]        cnt_q, cnt_nxt;
  logic [NBITS_O-1:0] pc_q, pc_nxt;
  logic [15:0]        pc_ext;
  logic [NBITS_B-1:0] report_byte;

  logic               wr_en_nxt, tx_start_nxt, cpu_rst_n_nxt, cpu_en_nxt;
  logic [NBITS_O-1:0] wr_addr_nxt;
  logic [NBITS_D-1:0] wr_data_nxt;
  logic [NBITS_B-1:0] tx_data_nxt;

  assign pc_ext = 16'(pc_q);

  always_comb begin
    unique case (k_q)
      2'd0:    report_byte = NBITS_B'(pc_ext[15:8]);
      2'd1:    report_byte = NBITS_B'(pc_ext[7:0]);
      2'd2:    report_byte = NBITS_B'(cnt_q[15:8]);
      default: report_byte = NBITS_B'(cnt_q[7:0]);
    endcase
  end

  always_comb begin
    state_nxt    = state;
    n_nxt        = n_q;
    idx_nxt      = idx_q;
    hi_nxt       = hi_q;
    k_nxt        = k_q;
    cnt_nxt      = cnt_q;
    pc_nxt       = pc_q;
    wr_en_nxt    = 1'b0;
    wr_addr_nxt  = o_PmWrAddr;
    wr_data_nxt  = o_PmWrData;
    tx_start_nxt = 1'b0;
    tx_data_nxt  = o_TxData;

    case (state)
      IDLE: begin
        if (i_RxDone) begin
          n_nxt     = i_RxData;
          idx_nxt   = '0;
          state_nxt = (i_RxData == '0) ? RUN : LD_HI;
        end
      end
      LD_HI: begin
        if (i_RxDone) begin
          hi_nxt    = i_RxData;
          state_nxt = LD_LO;
        end
      end
      LD_LO: begin
        if (i_RxDone) begin
          wr_en_nxt   = 1'b1;
          wr_addr_nxt = NBITS_O'(idx_q);
          wr_data_nxt = NBITS_D'({hi_q, i_RxData});
          idx_nxt     = idx_q + NBITS_B'(1);
          state_nxt   = ((idx_q + NBITS_B'(1)) == n_q) ? RUN : LD_HI;
        end
      end
      RUN: begin
        if (i_Halt) begin
          pc_nxt    = i_PmAddr;
          k_nxt     = 2'd0;
          state_nxt = SEND;
        end else if (cnt_q != 16'hFFFF) begin
          cnt_nxt = cnt_q + 16'd1;
        end
      end
      SEND: begin
        tx_start_nxt = 1'b1;
        tx_data_nxt  = report_byte;
        state_nxt    = WAIT_TX;
      end
      WAIT_TX: begin
        if (i_TxDone) begin
          if (k_q != 2'd3) begin
            k_nxt     = k_q + 2'd1;
            state_nxt = SEND;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    // counter restarts on every entry into RUN, so a halt on the entry cycle reports zero
    if (state != RUN && state_nxt == RUN) cnt_nxt = '0;

    cpu_rst_n_nxt = state_nxt inside {RUN, SEND, WAIT_TX};
    cpu_en_nxt    = (state_nxt == RUN);
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state      <= IDLE;
      n_q        <= '0;
      idx_q      <= '0;
      hi_q       <= '0;
      k_q        <= '0;
      cnt_q      <= '0;
      pc_q       <= '0;
      o_PmWrEn   <= 1'b0;
      o_PmWrAddr <= '0;
      o_PmWrData <= '0;
      o_CpuRstN  <= 1'b0;
      o_CpuEn    <= 1'b0;
      o_TxData   <= '0;
      o_TxStart  <= 1'b0;
    end else begin
      state      <= state_nxt;
      n_q        <= n_nxt;
      idx_q      <= idx_nxt;
      hi_q       <= hi_nxt;
      k_q        <= k_nxt;
      cnt_q      <= cnt_nxt;
      pc_q       <= pc_nxt;
      o_PmWrEn   <= wr_en_nxt;
      o_PmWrAddr <= wr_addr_nxt;
      o_PmWrData <= wr_data_nxt;
      o_CpuRstN  <= cpu_rst_n_nxt;
      o_CpuEn    <= cpu_en_nxt;
      o_TxData   <= tx_data_nxt;
      o_TxStart  <= tx_start_nxt;
    end
  end

endmodule

// File: tb/tb_debug_loader.sv
// Bench for debug_loader: cycle-exact driver with a transaction-level expectation model,
// per-cycle output comparison, and literal checks of the directed load/report scenarios.
module tb_debug_loader;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b0;
  logic [7:0]  i_RxData = '0;
  logic        i_RxDone = 1'b0;
  logic        i_TxDone = 1'b0;
  logic        i_Halt = 1'b0;
  logic [10:0] i_PmAddr = '0;
  logic        o_PmWrEn;
  logic [10:0] o_PmWrAddr;
  logic [15:0] o_PmWrData;
  logic        o_CpuRstN;
  logic        o_CpuEn;
  logic [7:0]  o_TxData;
  logic        o_TxStart;

  debug_loader #(.NBITS_O(11), .NBITS_D(16), .NBITS_B(8)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_RxData(i_RxData), .i_RxDone(i_RxDone),
    .i_TxDone(i_TxDone), .i_Halt(i_Halt), .i_PmAddr(i_PmAddr),
    .o_PmWrEn(o_PmWrEn), .o_PmWrAddr(o_PmWrAddr), .o_PmWrData(o_PmWrData),
    .o_CpuRstN(o_CpuRstN), .o_CpuEn(o_CpuEn), .o_TxData(o_TxData), .o_TxStart(o_TxStart)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  // expectation model: what each output must be in the current cycle
  logic        exp_wr = 1'b0, exp_tx = 1'b0, exp_rstn = 1'b0, exp_en = 1'b0;
  logic [10:0] exp_addr = '0;
  logic [15:0] exp_data = '0;
  logic [7:0]  exp_txd = '0;

  logic [26:0] got_wr[$];
  logic [7:0]  got_tx[$];
  logic        prev_wr = 1'b0, prev_tx = 1'b0;

  logic [7:0]  p_hi[16];
  logic [7:0]  p_lo[16];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, want, $time);
    end
  endtask

  always @(negedge i_clk) begin
    chk("pm_wr_en", 32'(o_PmWrEn), 32'(exp_wr));
    if (exp_wr) begin
      chk("pm_wr_addr", 32'(o_PmWrAddr), 32'(exp_addr));
      chk("pm_wr_data", 32'(o_PmWrData), 32'(exp_data));
    end
    chk("tx_start", 32'(o_TxStart), 32'(exp_tx));
    if (exp_tx) chk("tx_data", 32'(o_TxData), 32'(exp_txd));
    chk("cpu_rst_n", 32'(o_CpuRstN), 32'(exp_rstn));
    chk("cpu_en", 32'(o_CpuEn), 32'(exp_en));
    chk("strobe_overlap", 32'(o_PmWrEn & o_TxStart), 32'd0);
    chk("strobe_repeat", 32'((o_PmWrEn & prev_wr) | (o_TxStart & prev_tx)), 32'd0);
    if (o_PmWrEn) got_wr.push_back({o_PmWrAddr, o_PmWrData});
    if (o_TxStart) got_tx.push_back(o_TxData);
    prev_wr = o_PmWrEn;
    prev_tx = o_TxStart;
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
    exp_wr = 1'b0;
    exp_tx = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_wr_en"}, 32'(o_PmWrEn), 32'd0);
    chk({tag, "_wr_addr"}, 32'(o_PmWrAddr), 32'd0);
    chk({tag, "_wr_data"}, 32'(o_PmWrData), 32'd0);
    chk({tag, "_rst_n"}, 32'(o_CpuRstN), 32'd0);
    chk({tag, "_en"}, 32'(o_CpuEn), 32'd0);
    chk({tag, "_tx_data"}, 32'(o_TxData), 32'd0);
    chk({tag, "_tx_start"}, 32'(o_TxStart), 32'd0);
  endtask

  task automatic assert_reset_now();
    i_reset  = 1'b0;
    exp_wr   = 1'b0;
    exp_tx   = 1'b0;
    exp_rstn = 1'b0;
    exp_en   = 1'b0;
  endtask

  // one received byte, preceded by a random gap carrying ignored halt/tx noise
  task automatic rx_byte(input logic [7:0] b);
    repeat ($urandom_range(0, 2)) begin
      i_Halt   = 1'($urandom);
      i_TxDone = 1'($urandom);
      tick();
    end
    i_Halt   = 1'b0;
    i_TxDone = 1'b0;
    i_RxData = b;
    i_RxDone = 1'b1;
    tick();
    i_RxDone = 1'b0;
    i_RxData = 8'($urandom);
  endtask

  task automatic load_prog(input int n);
    rx_byte(8'(n));
    if (n == 0) begin
      exp_rstn = 1'b1;
      exp_en   = 1'b1;
    end
    for (int i = 0; i < n; i++) begin
      rx_byte(p_hi[i]);
      rx_byte(p_lo[i]);
      exp_wr   = 1'b1;
      exp_addr = 11'(i);
      exp_data = 16'(p_hi[i] * 256 + p_lo[i]);
      if (i == n - 1) begin
        exp_rstn = 1'b1;
        exp_en   = 1'b1;
      end
    end
  endtask

  // caller is in the first RUN cycle; halt arrives after h non-halt RUN cycles
  task automatic run_report(input int h, input logic [10:0] pc);
    int         cnt;
    logic [7:0] rep[4];
    cnt    = (h > 65535) ? 65535 : h;
    rep[0] = 8'(pc / 256);
    rep[1] = 8'(pc % 256);
    rep[2] = 8'(cnt / 256);
    rep[3] = 8'(cnt % 256);
    for (int c = 0; c < h; c++) begin
      i_Halt   = 1'b0;
      i_PmAddr = 11'($urandom);
      i_RxDone = 1'($urandom);
      i_RxData = 8'($urandom);
      i_TxDone = 1'($urandom);
      tick();
    end
    i_RxDone = 1'b0;
    i_TxDone = 1'b0;
    i_Halt   = 1'b1;
    i_PmAddr = pc;
    tick();
    exp_en   = 1'b0;
    i_Halt   = 1'($urandom);
    i_RxDone = 1'($urandom);
    i_TxDone = 1'($urandom);
    tick();
    i_Halt   = 1'b0;
    i_RxDone = 1'b0;
    i_TxDone = 1'b0;
    exp_tx   = 1'b1;
    exp_txd  = rep[0];
    for (int j = 0; j < 4; j++) begin
      repeat ($urandom_range(0, 4)) begin
        i_RxDone = 1'($urandom);
        i_Halt   = 1'($urandom);
        tick();
      end
      i_RxDone = 1'b0;
      i_Halt   = 1'b0;
      i_TxDone = 1'b1;
      tick();
      i_TxDone = 1'b0;
      if (j < 3) begin
        i_TxDone = 1'($urandom);
        i_RxDone = 1'($urandom);
        tick();
        i_TxDone = 1'b0;
        i_RxDone = 1'b0;
        exp_tx   = 1'b1;
        exp_txd  = rep[j+1];
      end else begin
        exp_rstn = 1'b0;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    #3;
    check_reset_outputs("por");
    repeat (2) @(posedge i_clk);
    #3 i_reset = 1'b1;

    // directed load of two words, then halt on the 10th RUN cycle at PC 0x405
    p_hi[0] = 8'h12; p_lo[0] = 8'h34;
    p_hi[1] = 8'hAB; p_lo[1] = 8'hCD;
    load_prog(2);
    chk("load_cpu_rst_n", 32'(o_CpuRstN), 32'd1);
    run_report(9, 11'h405);
    chk("load_wr_count", got_wr.size(), 32'd2);
    if (got_wr.size() == 2) begin
      chk("load_wr0", 32'(got_wr[0]), 32'({11'd0, 16'h1234}));
      chk("load_wr1", 32'(got_wr[1]), 32'({11'd1, 16'hABCD}));
    end
    chk("report_count", got_tx.size(), 32'd4);
    if (got_tx.size() == 4) begin
      chk("report_b0", 32'(got_tx[0]), 32'h04);
      chk("report_b1", 32'(got_tx[1]), 32'h05);
      chk("report_b2", 32'(got_tx[2]), 32'h00);
      chk("report_b3", 32'(got_tx[3]), 32'h09);
    end
    got_wr.delete();
    got_tx.delete();

    // zero count: straight to RUN, halt on the entry cycle
    load_prog(0);
    run_report(0, 11'h7FF);
    chk("zero_wr_count", got_wr.size(), 32'd0);
    chk("zero_tx_count", got_tx.size(), 32'd4);
    if (got_tx.size() == 4) begin
      chk("zero_b0", 32'(got_tx[0]), 32'h07);
      chk("zero_b2", 32'(got_tx[2]), 32'h00);
      chk("zero_b3", 32'(got_tx[3]), 32'h00);
    end
    got_tx.delete();

    // cycle counter saturation
    load_prog(0);
    run_report(70000, 11'h123);
    chk("sat_tx_count", got_tx.size(), 32'd4);
    if (got_tx.size() == 4) begin
      chk("sat_b2", 32'(got_tx[2]), 32'hFF);
      chk("sat_b3", 32'(got_tx[3]), 32'hFF);
    end
    got_tx.delete();

    // reset between the high and low byte of a word
    rx_byte(8'h02);
    rx_byte(8'h55);
    #2 assert_reset_now();
    #1 check_reset_outputs("rst_load");
    i_RxData = 8'h66;
    i_RxDone = 1'b1;
    tick();
    tick();
    i_RxDone = 1'b0;
    #2 i_reset = 1'b1;
    p_hi[0] = 8'hC3; p_lo[0] = 8'h3C;
    load_prog(1);
    i_RxData = 8'h77;
    i_RxDone = 1'b1;
    repeat (3) tick();
    #2 assert_reset_now();
    #1 check_reset_outputs("rst_run");
    tick();
    i_RxDone = 1'b0;
    #2 i_reset = 1'b1;
    chk("rst_wr_count", got_wr.size(), 32'd1);
    if (got_wr.size() == 1) chk("rst_wr0", 32'(got_wr[0]), 32'({11'd0, 16'hC33C}));
    chk("rst_tx_count", got_tx.size(), 32'd0);
    load_prog(0);
    run_report(3, 11'h0A5);
    got_wr.delete();
    got_tx.delete();

    // randomized programs and halt points
    for (int it = 0; it < 10; it++) begin
      int n;
      n = $urandom_range(0, 6);
      for (int i = 0; i < 16; i++) begin
        p_hi[i] = 8'($urandom);
        p_lo[i] = 8'($urandom);
      end
      load_prog(n);
      run_report($urandom_range(0, 40), 11'($urandom));
      chk("rand_wr_count", got_wr.size(), 32'(n));
      chk("rand_tx_count", got_tx.size(), 32'd4);
      got_wr.delete();
      got_tx.delete();
    end

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
